// File: rtl/dl11_fifo_regs.sv
// rtl/dl11_fifo_regs.sv - DL11 console register block with RX/TX byte FIFOs in front of a UART.
// Optional macro DL11_ERR_EN adds overrun/framing-error reporting in RBUF and RCSR.
module dl11_fifo_regs #(
  parameter logic [12:0] BASE   = 13'o17560,
  parameter logic [7:0]  VECTOR = 8'o60,
  parameter int          RX_AW  = 2,
  parameter int          TX_AW  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] iopage_addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        decode,
  input  logic        iopage_rd,
  input  logic        iopage_wr,
  input  logic        iopage_byte_op,
  output logic        interrupt,
  input  logic        interrupt_ack,
  output logic [7:0]  vector,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_ferr,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int RX_D = 1 << RX_AW;
  localparam int TX_D = 1 << TX_AW;
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_D);
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_D);

`ifdef DL11_ERR_EN
  localparam int RXW = 9;
  logic [RXW-1:0] w_rx_entry;
  assign w_rx_entry = {rx_ferr, rx_data};
`else
  localparam int RXW = 8;
  logic [RXW-1:0] w_rx_entry;
  logic           w_unused_ferr;
  assign w_rx_entry    = rx_data;
  assign w_unused_ferr = rx_ferr;
`endif

  logic             r_rd_q, r_wr_q, r_rie, r_xie, r_tx_req;
  logic [7:0]       r_xbuf;
  logic [RXW-1:0]   r_rx_mem [RX_D];
  logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
  logic [RX_AW:0]   r_rx_count;
  logic [7:0]       r_tx_mem [TX_D];
  logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
  logic [TX_AW:0]   r_tx_count;

  logic [1:0]       w_sel;
  logic             w_rd_first, w_wr_first, w_wr_any;
  logic [7:0]       w_wbyte;
  logic             w_rx_empty, w_rx_full, w_rx_pop, w_rx_push;
  logic             w_tx_empty, w_tx_full, w_tx_pop, w_tx_push;
  logic [RX_AW:0]   w_rx_count_next;
  logic [TX_AW:0]   w_tx_count_next;
  logic [RXW-1:0]   w_rx_head;
  logic [15:0]      w_rcsr, w_rbuf, w_word;
  logic             w_rx_irq, w_tx_irq, w_tx_set, w_tx_clr;

  assign decode     = iopage_addr[12:3] == BASE[12:3];
  assign w_sel      = iopage_addr[2:1];
  assign w_rd_first = iopage_rd & ~r_rd_q & decode;
  assign w_wr_first = iopage_wr & ~r_wr_q & decode;
  assign w_wr_any   = iopage_wr & decode;
  assign w_wbyte    = (iopage_byte_op & iopage_addr[0]) ? data_in[15:8] : data_in[7:0];

  // The RX side never back-pressures: a full FIFO only accepts when a pop frees a slot.
  assign w_rx_empty      = r_rx_count == '0;
  assign w_rx_full       = r_rx_count == RX_FULL;
  assign w_rx_pop        = w_rd_first & (w_sel == 2'd1) & ~w_rx_empty;
  assign w_rx_push       = rx_valid & (~w_rx_full | w_rx_pop);
  assign w_rx_count_next = r_rx_count + (RX_AW+1)'(w_rx_push) - (RX_AW+1)'(w_rx_pop);
  assign w_rx_head       = r_rx_mem[r_rx_rp];

  assign w_tx_empty      = r_tx_count == '0;
  assign w_tx_full       = r_tx_count == TX_FULL;
  assign w_tx_pop        = ~w_tx_empty & tx_ready;
  assign w_tx_push       = w_wr_first & (w_sel == 2'd3) & ~w_tx_full;
  assign w_tx_count_next = r_tx_count + (TX_AW+1)'(w_tx_push) - (TX_AW+1)'(w_tx_pop);

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= w_rx_entry;
    if (w_tx_push) r_tx_mem[r_tx_wp] <= w_wbyte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_q <= 1'b0; r_wr_q <= 1'b0; r_rie <= 1'b0; r_xie <= 1'b0;
      r_tx_req <= 1'b0; r_xbuf <= '0;
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_count <= '0;
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_count <= '0;
    end else begin
      r_rd_q     <= iopage_rd;
      r_wr_q     <= iopage_wr;
      r_rx_count <= w_rx_count_next;
      r_tx_count <= w_tx_count_next;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_wr_any && w_sel == 2'd0) r_rie  <= w_wbyte[6];
      if (w_wr_any && w_sel == 2'd2) r_xie  <= w_wbyte[6];
      if (w_wr_any && w_sel == 2'd3) r_xbuf <= w_wbyte;
      if (w_tx_set)      r_tx_req <= 1'b1;
      else if (w_tx_clr) r_tx_req <= 1'b0;
    end
  end

`ifdef DL11_ERR_EN
  logic r_ovr, w_ferr, w_err;
  assign w_ferr = ~w_rx_empty & w_rx_head[8];
  assign w_err  = r_ovr | w_ferr;
  assign w_rcsr = {w_err, 7'b0, ~w_rx_empty, r_rie, 6'b0};
  assign w_rbuf = w_rx_empty ? 16'h0 : {w_err, r_ovr, w_ferr, 5'b0, w_rx_head[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_ovr <= 1'b0;
    else if (w_rx_pop)               r_ovr <= 1'b0;
    else if (rx_valid && w_rx_full)  r_ovr <= 1'b1;
  end
`else
  assign w_rcsr = {8'b0, ~w_rx_empty, r_rie, 6'b0};
  assign w_rbuf = w_rx_empty ? 16'h0 : {8'b0, w_rx_head};
`endif

  // TX request latches on READY rising, or on XIE being enabled while already READY.
  assign w_rx_irq = r_rie & ~w_rx_empty;
  assign w_tx_irq = r_xie & r_tx_req;
  assign w_tx_set = (w_tx_full & (w_tx_count_next != TX_FULL)) |
                    (w_wr_any & (w_sel == 2'd2) & w_wbyte[6] & ~r_xie & ~w_tx_full);
  assign w_tx_clr = interrupt_ack & ~w_rx_irq & w_tx_irq;

  always_comb begin
    w_word = 16'h0;
    case (w_sel)
      2'd0: w_word = w_rcsr;
      2'd1: w_word = w_rbuf;
      2'd2: w_word = {8'b0, ~w_tx_full, r_xie, 6'b0};
      default: w_word = {8'b0, r_xbuf};
    endcase
    data_out = 16'h0;
    if (decode) begin
      if (iopage_byte_op) data_out = {8'b0, iopage_addr[0] ? w_word[15:8] : w_word[7:0]};
      else                data_out = w_word;
    end
  end

  assign interrupt = w_rx_irq | w_tx_irq;
  assign vector    = w_rx_irq ? VECTOR : (w_tx_irq ? 8'(VECTOR + 8'd4) : 8'h0);
  assign rx_ready  = 1'b1;
  assign tx_valid  = ~w_tx_empty;
  assign tx_data   = r_tx_mem[r_tx_rp];
endmodule

// File: tb/tb_dl11_fifo_regs.sv
// tb/tb_dl11_fifo_regs.sv - queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_dl11_fifo_regs;
  localparam logic [12:0] BASE   = 13'o17560;
  localparam logic [7:0]  VECTOR = 8'o60;
  localparam int RXD = 4;
  localparam int TXD = 4;
`ifdef DL11_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic [12:0] iopage_addr = '0;
  logic [15:0] data_in = '0, data_out;
  logic        decode, iopage_rd = 1'b0, iopage_wr = 1'b0, iopage_byte_op = 1'b0;
  logic        interrupt, interrupt_ack = 1'b0;
  logic [7:0]  vector;
  logic        rx_valid = 1'b0, rx_ferr = 1'b0, rx_ready;
  logic [7:0]  rx_data = '0, tx_data;
  logic        tx_valid, tx_ready = 1'b1;

  dl11_fifo_regs #(.BASE(BASE), .VECTOR(VECTOR), .RX_AW(2), .TX_AW(2)) dut (
    .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
    .data_out(data_out), .decode(decode), .iopage_rd(iopage_rd), .iopage_wr(iopage_wr),
    .iopage_byte_op(iopage_byte_op), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .vector(vector), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ferr(rx_ferr),
    .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  logic [8:0] m_rxq[$];
  logic [7:0] m_txq[$];
  bit m_rie, m_xie, m_ovr, m_txreq, m_rdq, m_wrq;
  logic [7:0] m_xbuf;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rxq.delete(); m_txq.delete();
    m_rie = 0; m_xie = 0; m_ovr = 0; m_txreq = 0; m_rdq = 0; m_wrq = 0; m_xbuf = '0;
  endtask

  function automatic bit exp_rx_irq(); return m_rie && m_rxq.size() > 0; endfunction
  function automatic bit exp_tx_irq(); return m_xie && m_txreq; endfunction

  function automatic logic [15:0] exp_word(logic [1:0] sel);
    bit done, ferr, err;
    logic [7:0] hd;
    done = m_rxq.size() > 0;
    hd   = done ? m_rxq[0][7:0] : 8'h0;
    ferr = done ? m_rxq[0][8] : 1'b0;
    err  = ERR_EN && (m_ovr || ferr);
    case (sel)
      2'd0: return {err, 7'b0, done, m_rie, 6'b0};
      2'd1: return done ? {err, ERR_EN && m_ovr, ferr, 5'b0, hd} : 16'h0;
      2'd2: return {8'b0, m_txq.size() < TXD, m_xie, 6'b0};
      default: return {8'b0, m_xbuf};
    endcase
  endfunction

  function automatic logic [15:0] exp_dout();
    logic [15:0] w;
    if (iopage_addr[12:3] != BASE[12:3]) return 16'h0;
    w = exp_word(iopage_addr[2:1]);
    if (iopage_byte_op) return {8'b0, iopage_addr[0] ? w[15:8] : w[7:0]};
    return w;
  endfunction

  function automatic logic [7:0] exp_vec();
    if (exp_rx_irq()) return VECTOR;
    if (exp_tx_irq()) return VECTOR + 8'd4;
    return 8'h0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    bit dec, rdf, wrf, wra, pop, presented, ready_before, set;
    logic [1:0] sel;
    logic [7:0] lo;
    int rxs, txs;
    dec = iopage_addr[12:3] == BASE[12:3];
    sel = iopage_addr[2:1];
    rdf = iopage_rd && !m_rdq && dec;
    wrf = iopage_wr && !m_wrq && dec;
    wra = iopage_wr && dec;
    lo  = (iopage_byte_op && iopage_addr[0]) ? data_in[15:8] : data_in[7:0];
    rxs = m_rxq.size(); txs = m_txq.size();
    presented    = exp_tx_irq() && !exp_rx_irq();
    ready_before = txs < TXD;
    pop = rdf && sel == 2'd1 && rxs > 0;
    if (pop) begin void'(m_rxq.pop_front()); m_ovr = 0; end
    if (rx_valid) begin
      if (pop || rxs < RXD) m_rxq.push_back({ERR_EN ? rx_ferr : 1'b0, rx_data});
      else if (ERR_EN) m_ovr = 1;
    end
    if (txs > 0 && tx_ready) void'(m_txq.pop_front());
    if (wrf && sel == 2'd3 && txs < TXD) m_txq.push_back(lo);
    if (wra && sel == 2'd3) m_xbuf = lo;
    set = (!ready_before && m_txq.size() < TXD) ||
          (wra && sel == 2'd2 && lo[6] && !m_xie && ready_before);
    if (set) m_txreq = 1;
    else if (interrupt_ack && presented) m_txreq = 0;
    if (wra && sel == 2'd0) m_rie = lo[6];
    if (wra && sel == 2'd2) m_xie = lo[6];
    m_rdq = iopage_rd; m_wrq = iopage_wr;
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("decode", {15'b0, decode}, {15'b0, iopage_addr[12:3] == BASE[12:3]});
      chk("data_out", data_out, exp_dout());
      chk("interrupt", {15'b0, interrupt}, {15'b0, exp_rx_irq() || exp_tx_irq()});
      chk("vector", {8'b0, vector}, {8'b0, exp_vec()});
      chk("tx_valid", {15'b0, tx_valid}, {15'b0, m_txq.size() > 0});
      chk("rx_ready", {15'b0, rx_ready}, 16'h1);
      if (m_txq.size() > 0) chk("tx_data", {8'b0, tx_data}, {8'b0, m_txq[0]});
    end
  end

  task automatic tick(); @(posedge clk); model_update(); #1; endtask

  task automatic cpu_write(logic [12:0] a, logic [15:0] d);
    iopage_addr = a; data_in = d; iopage_byte_op = 0; iopage_wr = 1;
    tick(); iopage_wr = 0; tick();
  endtask

  task automatic cpu_read(logic [12:0] a, int hold, output logic [15:0] d);
    iopage_addr = a; iopage_byte_op = 0; iopage_rd = 1; #1;
    d = data_out;
    repeat (hold) tick();
    iopage_rd = 0; tick();
  endtask

  task automatic peek(logic [12:0] a, string name, logic [15:0] exp);
    iopage_addr = a; iopage_byte_op = 0; #1;
    chk(name, data_out, exp);
  endtask

  logic [15:0] rd;
  logic [7:0]  got[$];
  int hold;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0; chk_en = 1;
    peek(BASE + 13'd4, "reset_xcsr", 16'o000200);
    chk("reset_irq", {15'b0, interrupt}, 16'h0);
    chk("reset_vec", {8'b0, vector}, 16'h0);

    cpu_write(BASE + 13'd4, 16'o100);
    chk("xie_irq", {15'b0, interrupt}, 16'h1);
    chk("xie_vec", {8'b0, vector}, 16'o64);
    interrupt_ack = 1; tick(); interrupt_ack = 0;
    chk("ack_clears", {15'b0, interrupt}, 16'h0);

    tx_ready = 0;
    for (int i = 0; i < 4; i++) cpu_write(BASE + 13'd6, 16'h41 + 16'(i));
    peek(BASE + 13'd4, "tx_full_xcsr", 16'o000100);
    cpu_write(BASE + 13'd6, 16'h45);
    tx_ready = 1;
    for (int i = 0; i < 20 && got.size() < 4; i++) begin
      if (tx_valid) got.push_back(tx_data);
      tick();
    end
    chk("tx_count", 16'(got.size()), 16'd4);
    for (int i = 0; i < got.size(); i++) chk("tx_order", {8'b0, got[i]}, 16'h41 + 16'(i));
    chk("tx_drained", {15'b0, tx_valid}, 16'h0);
    peek(BASE + 13'd4, "tx_ready_back", 16'o000300);
    chk("ready_rise_vec", {8'b0, vector}, 16'o64);
    interrupt_ack = 1; tick(); interrupt_ack = 0;

    cpu_write(BASE, 16'o100);
    rx_valid = 1; rx_data = 8'h0D; rx_ferr = 0; tick(); rx_valid = 0;
    peek(BASE, "rcsr_done", 16'o300);
    chk("rx_vec", {8'b0, vector}, 16'o60);
    cpu_read(BASE + 13'd2, 4, rd);
    chk("rbuf_0d", rd, 16'h000D);
    peek(BASE, "rcsr_after_pop", 16'o100);
    chk("rx_irq_gone", {15'b0, interrupt}, 16'h0);

    cpu_write(BASE, 16'o0);
    for (int i = 1; i <= 5; i++) begin rx_valid = 1; rx_data = 8'(i); tick(); end
    rx_valid = 0;
    cpu_read(BASE + 13'd2, 1, rd);
    chk("rbuf_ovr", rd, ERR_EN ? 16'o140001 : 16'o000001);
    for (int i = 2; i <= 4; i++) begin
      cpu_read(BASE + 13'd2, 1, rd);
      chk("rbuf_seq", rd, 16'(i));
    end
    peek(BASE, "rx_empty", 16'o0);

    tx_ready = 0;
    for (int i = 0; i < 3; i++) cpu_write(BASE + 13'd6, 16'h60 + 16'(i));
    cpu_write(BASE, 16'o100);
    rx_valid = 1; rx_data = 8'h33; tick(); rx_valid = 0;
    chk("pre_reset_irq", {15'b0, interrupt}, 16'h1);
    #2 reset = 1; #1;
    model_reset();
    chk("async_tx_valid", {15'b0, tx_valid}, 16'h0);
    chk("async_irq", {15'b0, interrupt}, 16'h0);
    chk("async_vec", {8'b0, vector}, 16'h0);
    @(negedge clk); reset = 0; tx_ready = 1;
    peek(BASE + 13'd4, "post_reset_xcsr", 16'o000200);

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        iopage_rd = 0; iopage_wr = 0;
        if ($urandom_range(0, 2) == 0) begin
          iopage_byte_op = $urandom_range(0, 3) == 0;
          if ($urandom_range(0, 9) < 9)
            iopage_addr = BASE + {10'b0, 2'($urandom_range(0, 3)), 1'b0} +
                          (iopage_byte_op ? 13'($urandom_range(0, 1)) : 13'd0);
          else
            iopage_addr = 13'($urandom);
          data_in = 16'($urandom);
          if ($urandom_range(0, 1) == 1) iopage_rd = 1; else iopage_wr = 1;
          hold = $urandom_range(1, 4);
        end
      end else hold--;
      rx_valid      = $urandom_range(0, 3) == 0;
      rx_data       = 8'($urandom);
      rx_ferr       = $urandom_range(0, 7) == 0;
      tx_ready      = $urandom_range(0, 1) == 1;
      interrupt_ack = $urandom_range(0, 6) == 0;
      tick();
    end
    interrupt_ack = 0; iopage_rd = 0; iopage_wr = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
